// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Holds the FSM state enum, the 4x4 key-code table and bit helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEB_PRESS,
        ST_PRESSED,
        ST_DEB_REL
    } scan_state_e;

    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    function automatic int onehot_to_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    // row_idx is the row_in bit index; bit 3 is the top row on a 4x4 pad.
    function automatic int key_lut(
        input int col_idx,
        input int row_idx,
        input int n_cols,
        input int n_rows
    );
        logic [3:0] sel;
        logic [3:0] code;
        if (n_cols == 4 && n_rows == 4) begin
            sel = {col_idx[1:0], row_idx[1:0]};
            case (sel)
                4'b00_11: code = 4'h1;
                4'b00_10: code = 4'h4;
                4'b00_01: code = 4'h7;
                4'b00_00: code = 4'hE;
                4'b01_11: code = 4'h2;
                4'b01_10: code = 4'h5;
                4'b01_01: code = 4'h8;
                4'b01_00: code = 4'h0;
                4'b10_11: code = 4'h3;
                4'b10_10: code = 4'h6;
                4'b10_01: code = 4'h9;
                4'b10_00: code = 4'hF;
                4'b11_11: code = 4'hA;
                4'b11_10: code = 4'hB;
                4'b11_01: code = 4'hC;
                default:  code = 4'hD;
            endcase
            return int'(code);
        end
        return col_idx * n_rows + row_idx;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce_counter.sv
// Consecutive-match counter shared by the press and release debounce phases.
// done fires combinationally on the LIMIT-th consecutive match.
module debounce_counter
    import keypad_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic match,
    output logic done
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (match) begin
            cnt <= cnt + W'(1);
        end
    end

    assign done = match && !clear && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: one-hot column strobe, press/release debounce,
// single-pulse key codes, hold status and multi-key rejection.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int N_COLS       = 4,
    parameter int N_ROWS       = 4,
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8,
    parameter int KEY_W        = 4
) (
    input  logic              slow_clk,
    input  logic              rst,
    input  logic [N_ROWS-1:0] row_in,
    output logic [N_COLS-1:0] col_drive,
    output logic [KEY_W-1:0]  key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              multi_key
);

    localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int CIDX_W  = $clog2(N_COLS);

    scan_state_e       state;
    logic [CNT_W-1:0]  dwell;
    logic [N_ROWS-1:0] cap_row;
    logic [CIDX_W-1:0] cap_col;

    logic              row_zero;
    logic              row_one;
    logic              dwell_last;
    logic [N_COLS-1:0] col_next;
    logic [CIDX_W-1:0] col_idx;
    logic [KEY_W-1:0]  key_sel;
    logic              deb_match;
    logic              deb_clear;
    logic              deb_done;

    always_comb begin
        row_zero   = (row_in == '0);
        row_one    = (popcount(32'(row_in)) == 1);
        dwell_last = (dwell == CNT_W'(SCAN_DIV - 1));
        col_next   = {col_drive[N_COLS-2:0], col_drive[N_COLS-1]};
        col_idx    = CIDX_W'(onehot_to_idx(32'(col_drive)));
        key_sel    = KEY_W'(key_lut(int'(cap_col),
                                    onehot_to_idx(32'(cap_row)),
                                    N_COLS, N_ROWS));
        deb_match  = ((state == ST_DEB_PRESS) && (row_in == cap_row))
                  || ((state == ST_DEB_REL) && row_zero);
        deb_clear  = (state == ST_SCAN) || (state == ST_PRESSED);
    end

    // Counter is cleared in the non-debounce states, so each phase starts at zero.
    debounce_counter #(
        .LIMIT (DEBOUNCE_CNT)
    ) u_deb (
        .clk   (slow_clk),
        .rst   (rst),
        .clear (deb_clear),
        .match (deb_match),
        .done  (deb_done)
    );

    always_ff @(posedge slow_clk) begin
        if (rst) begin
            state     <= ST_SCAN;
            dwell     <= '0;
            cap_row   <= '0;
            cap_col   <= '0;
            col_drive <= N_COLS'(1);
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            multi_key <= 1'b0;
            unique case (state)
                ST_SCAN: begin
                    if (dwell_last) begin
                        dwell <= '0;
                        if (row_one) begin
                            cap_row <= row_in;
                            cap_col <= col_idx;
                            state   <= ST_DEB_PRESS;
                        end else begin
                            col_drive <= col_next;
                            multi_key <= !row_zero;
                        end
                    end else begin
                        dwell <= dwell + CNT_W'(1);
                    end
                end
                ST_DEB_PRESS: begin
                    if (deb_done) begin
                        state     <= ST_PRESSED;
                        key_code  <= key_sel;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                    end else if (!deb_match) begin
                        state     <= ST_SCAN;
                        col_drive <= col_next;
                    end
                end
                ST_PRESSED: begin
                    if (row_zero) begin
                        state <= ST_DEB_REL;
                    end
                end
                ST_DEB_REL: begin
                    if (deb_done) begin
                        state     <= ST_SCAN;
                        key_held  <= 1'b0;
                        col_drive <= col_next;
                    end else if (!row_zero) begin
                        state <= ST_PRESSED;
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a behavioural reference model
// checked on every cycle plus literal expectations per scenario.
module tb_keypad_scan_debounce;

    localparam int NC  = 4;
    localparam int NR  = 4;
    localparam int DIV = 2;
    localparam int DEB = 3;

    logic       slow_clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    int checks = 0;
    int errors = 0;
    int vc = 0;
    int mc = 0;

    keypad_scan_debounce #(
        .N_COLS       (NC),
        .N_ROWS       (NR),
        .SCAN_DIV     (DIV),
        .DEBOUNCE_CNT (DEB),
        .KEY_W        (4)
    ) dut (
        .slow_clk  (slow_clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_drive (col_drive),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    initial slow_clk = 1'b0;
    always #5 slow_clk = ~slow_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: keypad layout rows top-to-bottom (row_in MSB first).
    int tbl [4][4] = '{'{1, 4, 7, 14}, '{2, 5, 8, 0}, '{3, 6, 9, 15}, '{10, 11, 12, 13}};

    int         m_mode;
    int         m_col;
    int         m_tick;
    int         m_streak;
    logic [3:0] m_row;
    int         e_code;
    bit         e_valid;
    bit         e_held;
    bit         e_multi;
    bit         m_init = 1'b0;

    function automatic int top_pos(input logic [3:0] r);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) p = 3 - i;
        end
        return p;
    endfunction

    task automatic model_step(input bit r_rst, input logic [3:0] r);
        int ones;
        e_valid = 1'b0;
        e_multi = 1'b0;
        if (r_rst) begin
            m_mode = 0; m_col = 0; m_tick = 0; m_streak = 0; m_row = '0;
            e_code = 0; e_held = 1'b0;
            m_init = 1'b1;
        end else if (m_init) begin
            ones = $countones(r);
            case (m_mode)
                0: begin
                    m_tick++;
                    if (m_tick == DIV) begin
                        m_tick = 0;
                        if (ones == 1) begin
                            m_mode = 1; m_row = r; m_streak = 0;
                        end else begin
                            m_col = (m_col + 1) % NC;
                            e_multi = (ones > 1);
                        end
                    end
                end
                1: begin
                    if (r == m_row) begin
                        m_streak++;
                        if (m_streak == DEB) begin
                            m_mode = 2;
                            e_code = tbl[m_col][top_pos(m_row)];
                            e_valid = 1'b1;
                            e_held = 1'b1;
                        end
                    end else begin
                        m_mode = 0;
                        m_col = (m_col + 1) % NC;
                    end
                end
                2: begin
                    if (ones == 0) begin
                        m_mode = 3; m_streak = 0;
                    end
                end
                default: begin
                    if (ones == 0) begin
                        m_streak++;
                        if (m_streak == DEB) begin
                            m_mode = 0; e_held = 1'b0;
                            m_col = (m_col + 1) % NC;
                        end
                    end else begin
                        m_mode = 2;
                    end
                end
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge slow_clk);
            model_step(rst, row_in);
            @(negedge slow_clk);
            if (m_init) begin
                chk("m_col", 32'(col_drive), 32'(1 << m_col));
                chk("m_code", 32'(key_code), 32'(e_code));
                chk("m_valid", 32'(key_valid), 32'(e_valid));
                chk("m_held", 32'(key_held), 32'(e_held));
                chk("m_multi", 32'(multi_key), 32'(e_multi));
                chk("m_excl", 32'(key_valid & multi_key), 0);
                if (key_valid === 1'b1) vc++;
                if (multi_key === 1'b1) mc++;
            end
        end
    end

    task automatic drive(input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            row_in = r;
            @(negedge slow_clk);
        end
    endtask

    task automatic wait_col(input logic [3:0] c);
        int n;
        n = 0;
        while (col_drive == c && n < 40) begin
            @(negedge slow_clk); n++;
        end
        while (col_drive != c && n < 40) begin
            @(negedge slow_clk); n++;
        end
        chk("wait_col", 32'(col_drive), 32'(c));
    endtask

    int by_bit [16] = '{14, 7, 4, 1, 0, 8, 5, 2, 15, 9, 6, 3, 13, 12, 11, 10};

    initial begin
        int v0;
        rst = 1'b1;
        row_in = '0;
        repeat (2) @(negedge slow_clk);
        chk("rst_col", 32'(col_drive), 1);
        chk("rst_code", 32'(key_code), 0);
        chk("rst_flags", 32'({key_valid, key_held, multi_key}), 0);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge slow_clk);
            chk("scan_rot", 32'(col_drive), 32'(4'b0001 << ((i / 2) % 4)));
        end

        wait_col(4'b0010);
        drive(4'b0100, 8);
        chk("t2_code", 32'(key_code), 5);
        chk("t2_held", 32'(key_held), 1);
        chk("t2_col", 32'(col_drive), 32'(4'b0010));
        chk("t2_pulses", vc, 1);
        drive(4'b0000, 4);
        chk("t2_rel", 32'(key_held), 0);
        chk("t2_next", 32'(col_drive), 32'(4'b0100));

        wait_col(4'b0010);
        drive(4'b0100, 2);
        drive(4'b0000, 1);
        chk("t3_col", 32'(col_drive), 32'(4'b0100));
        chk("t3_pulses", vc, 1);

        wait_col(4'b0001);
        drive(4'b1010, 2);
        chk("t4_multi", 32'(multi_key), 1);
        chk("t4_col", 32'(col_drive), 32'(4'b0010));
        drive(4'b0000, 1);
        chk("t4_multi_off", 32'(multi_key), 0);
        chk("t4_mcount", mc, 1);
        chk("t4_pulses", vc, 1);

        wait_col(4'b0001);
        drive(4'b0010, 6);
        chk("t5_code", 32'(key_code), 7);
        drive(4'b0000, 2);
        drive(4'b0100, 1);
        drive(4'b0000, 3);
        chk("t5_still_held", 32'(key_held), 1);
        drive(4'b0000, 1);
        chk("t5_rel", 32'(key_held), 0);
        chk("t5_pulses", vc, 2);

        wait_col(4'b1000);
        drive(4'b0001, 6);
        chk("t6_code", 32'(key_code), 13);
        chk("t6_held", 32'(key_held), 1);
        rst = 1'b1;
        row_in = '0;
        @(negedge slow_clk);
        chk("t6_col", 32'(col_drive), 1);
        chk("t6_code_rst", 32'(key_code), 0);
        chk("t6_flags", 32'({key_valid, key_held, multi_key}), 0);
        rst = 1'b0;
        drive(4'b0000, 1);

        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 4; b++) begin
                v0 = vc;
                wait_col(4'(1 << c));
                drive(4'(1 << b), 6);
                chk("t7_code", 32'(key_code), 32'(by_bit[c*4+b]));
                chk("t7_pulse", vc - v0, 1);
                drive(4'b0000, 4);
                chk("t7_rel", 32'(key_held), 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
